cp0_ctrl: RTL and testbench
===========================

# cp0_ctrl

Parametrised coprocessor-0 block for the MIPS core: banked CP0 register storage (MTC0/MFC0 with sel field) plus hardware-managed Status, Cause and EPC with interrupt latching, prioritisation, entry handshake and ERET return. It sits beside the register file in the ID/WB stages and drives the core's interrupt-entry and ERET-return logic.

## Interface
- WIDTH, 32: data width (≥ 16).
- NUM_SEL, 8: sel banks per register number (power of 2, 1..8); SELW = max(1, log2(NUM_SEL)).
- NUM_IRQ, 8: interrupt lines (1..8).

- clk  in  1  clock, all state on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- r_addr  in  5 / r_sel  in  SELW: MFC0 read address.
- r_data  out  WIDTH: combinational read of the current registered value; no write-through.
- w_en  in  1 / w_addr  in  5 / w_sel  in  SELW / w_data  in  WIDTH: MTC0 write.
- irq  in  NUM_IRQ: level inputs, already synchronous to clk.
- irq_req  out  1: interrupt pending and enabled.
- irq_id  out  3: index of the highest-priority pending, unmasked line (lowest index wins); 0 when irq_req=0.
- irq_ack  in  1: core takes the interrupt this cycle.
- epc_in  in  WIDTH: return PC captured on irq_ack.
- eret  in  1: ERET executed.
- epc_out  out  WIDTH: current EPC.
- status_exl  out  1: current Status.EXL.

## Operation
- Register map, sel=0: 12 Status, 13 Cause, 14 EPC. All other (addr, sel) pairs are plain WIDTH-bit storage. Status/Cause/EPC have no copies at sel≠0; those pairs are plain storage.
- Status: bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM. Other bits are plain storage.
- Cause: bits[8+NUM_IRQ-1:8] IP, bits[6:2] ExcCode (0 = interrupt). Other bits read 0 and ignore writes.
- Edge capture: rising edge on irq[i] (irq=1, previous sample 0) sets IP[i]. IP is sticky.
- irq_req = IE & ~EXL & |(IP & IM).
- irq_ack with irq_req=1 has these effects:
  - EPC ← epc_in.
  - EXL ← 1.
  - ExcCode ← 0.
  - IP[irq_id] ← 0.
- irq_ack with irq_req=0 is ignored.
- eret: EXL ← 0. If EXL is already 0, there is no effect.

Precedence on the same edge:
- irq_ack and eret together: ack applies, eret is ignored.
- Hardware EXL/EPC update and an MTC0 to the same register: the hardware field wins. The other written bits take w_data.
- New irq edge and a clear of the same IP bit (by ack or MTC0): the set wins; the edge is never lost.
- MTC0 to Cause: IP ← w_data IP | new edges.

## Timing
- Reset: every storage word, Status, Cause, EPC and the irq sample register clear to 0. Consequently irq_req=0, irq_id=0, epc_out=0, status_exl=0, r_data=0.
- irq goes high before edge k:
  - IP set at edge k.
  - irq_req high after edge k, if enabled; one cycle latency.
- irq_ack sampled at edge k: EPC, EXL and IP updated after edge k. irq_req falls in the same cycle.
- MTC0 at edge k: visible on r_data from cycle k+1.
- clr mid-handshake aborts the handshake. All state returns to reset values; a line held high does not re-trigger until it sees a fresh 0→1.

## Structure
- Package cp0_pkg holds:
  - register-number constants (12/13/14);
  - Status/Cause bit positions (IE, EXL, IM_LO, IP_LO, EXC_LO/HI);
  - EXC_INT = 0.
- Sub-module cp0_irq_latch handles edge detection, sticky IP, set/clear precedence and the priority encoder. It is parametrised by NUM_IRQ.
- Storage: a 32×NUM_SEL array. The Status/Cause/EPC entries are overridden by dedicated registers.

## Test plan
- Reset, then MTC0 writes to (5, sel 3) ← 0xDEADBEEF and (5, sel 0) ← 0x1 → reads return 0xDEADBEEF and 0x1 respectively. clr pulse → both read 0.
- Status ← 0x0000_0301 (IE, IM0, IM1); pulse irq[1] then irq[0] → irq_req=1, irq_id=0. Ack with epc_in=0x0040_0010 → epc_out=0x0040_0010, status_exl=1, Cause IP=0x02, irq_req=0.
- ERET → EXL=0, irq_req=1, irq_id=1. Ack → IP=0.
- irq_ack and eret on the same edge with EXL=0 → EXL=1 after the edge.
- irq[2] rising edge on the same edge as MTC0 Cause ← 0 → IP[2]=1.
- Hold irq[0]=1 across several cycles after an ack → IP[0] stays 0 and no re-request occurs. Lower then raise irq[0] → IP[0]=1.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 block. These are the register
// numbers that hardware manages, the Status and Cause field positions, and
// the interrupt exception code.
package cp0_pkg;
  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_IP_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;

  localparam logic [4:0] EXC_INT = 5'd0;
endpackage

// File: rtl/cp0_irq_latch.sv
// Interrupt edge capture, sticky pending bits (Cause.IP) and the priority
// encoder.
// Ports:
//   clk, clr     clock and async active-high reset
//   irq          level interrupt lines, already synchronous to clk
//   wr_en/wr_ip  software (MTC0) load of the whole IP field
//   ack          interrupt taken this cycle; clears the winning IP bit
//   im           interrupt mask (Status.IM)
//   ip           current pending bits
//   pend         some pending bit is unmasked
//   pend_id      lowest-index pending, unmasked line (0 if none)
module cp0_irq_latch
  import cp0_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               wr_en,
  input  logic [NUM_IRQ-1:0] wr_ip,
  input  logic               ack,
  input  logic [NUM_IRQ-1:0] im,
  output logic [NUM_IRQ-1:0] ip,
  output logic               pend,
  output logic [2:0]         pend_id
);

  logic [NUM_IRQ-1:0] irq_q;
  logic               primed;
  logic [NUM_IRQ-1:0] edges;
  logic [NUM_IRQ-1:0] masked;
  logic [NUM_IRQ-1:0] pick;
  logic [NUM_IRQ-1:0] ip_next;

  // The sample register clears to 0 on reset, so a line already high would
  // look like a fresh edge on the first cycle out of reset. 'primed' blocks
  // edge detection for that first cycle, so only a real 0->1 counts.
  assign edges  = primed ? (irq & ~irq_q) : '0;
  assign masked = ip & im;
  assign pend   = |masked;

  // Descending scan so the lowest index is the last assignment and wins.
  always_comb begin
    pend_id = 3'd0;
    pick    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        pend_id = 3'(i);
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

  // Software load first, then the acknowledge clear, then new edges OR'd in
  // last, so an edge arriving on the same cycle as a clear is never lost.
  always_comb begin
    ip_next = wr_en ? wr_ip : ip;
    if (ack) ip_next = ip_next & ~pick;
    ip_next = ip_next | edges;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      irq_q  <= '0;
      primed <= 1'b0;
      ip     <= '0;
    end else begin
      irq_q  <= irq;
      primed <= 1'b1;
      ip     <= ip_next;
    end
  end

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 block. It holds banked CP0 storage for MTC0/MFC0 and the
// hardware-managed Status (12), Cause (13) and EPC (14) registers at sel 0.
// Ports:
//   clk, clr                         clock and async active-high reset
//   r_addr/r_sel -> r_data           combinational MFC0 read, no write-through
//   w_en/w_addr/w_sel/w_data         MTC0 write
//   irq                              interrupt lines (edge captured)
//   irq_req/irq_id                   interrupt request and winning line
//   irq_ack/epc_in                   core takes the interrupt, return PC
//   eret                             return from exception (clears EXL)
//   epc_out/status_exl               current EPC and Status.EXL
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SEL = 8,
  parameter int NUM_IRQ = 8,
  localparam int SELW   = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [4:0]         r_addr,
  input  logic [SELW-1:0]    r_sel,
  output logic [WIDTH-1:0]   r_data,
  input  logic               w_en,
  input  logic [4:0]         w_addr,
  input  logic [SELW-1:0]    w_sel,
  input  logic [WIDTH-1:0]   w_data,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               irq_req,
  output logic [2:0]         irq_id,
  input  logic               irq_ack,
  input  logic [WIDTH-1:0]   epc_in,
  input  logic               eret,
  output logic [WIDTH-1:0]   epc_out,
  output logic               status_exl
);

  localparam int SBITS = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 0;
  localparam int IW    = 5 + SBITS;
  localparam int DEPTH = 32 * NUM_SEL;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] epc;
  logic [4:0]       exc;
  logic [WIDTH-1:0] cause_val;

  logic [IW-1:0] r_idx, w_idx;
  logic          r_ok, w_ok;

  logic [NUM_IRQ-1:0] ip;
  logic               pend;
  logic [2:0]         pend_id;
  logic               ack_take;
  logic               w_status, w_cause, w_epc, w_plain;

  // With a single bank the sel field is one bit wide, but only sel 0 exists.
  // Other sel values read 0 and ignore writes.
  if (NUM_SEL == 1) begin : g_flat
    assign r_idx = r_addr;
    assign w_idx = w_addr;
    assign r_ok  = (r_sel == '0);
    assign w_ok  = (w_sel == '0);
  end else begin : g_banked
    assign r_idx = {r_addr, r_sel};
    assign w_idx = {w_addr, w_sel};
    assign r_ok  = 1'b1;
    assign w_ok  = 1'b1;
  end

  assign w_status = w_en && (w_sel == '0) && (w_addr == REG_STATUS);
  assign w_cause  = w_en && (w_sel == '0) && (w_addr == REG_CAUSE);
  assign w_epc    = w_en && (w_sel == '0) && (w_addr == REG_EPC);
  assign w_plain  = w_en && w_ok && !w_status && !w_cause && !w_epc;

  assign irq_req    = status[ST_IE] & ~status[ST_EXL] & pend;
  assign irq_id     = irq_req ? pend_id : 3'd0;
  assign ack_take   = irq_ack & irq_req;
  assign epc_out    = epc;
  assign status_exl = status[ST_EXL];

  cp0_irq_latch #(.NUM_IRQ(NUM_IRQ)) u_latch (
    .clk     (clk),
    .clr     (clr),
    .irq     (irq),
    .wr_en   (w_cause),
    .wr_ip   (w_data[CA_IP_LO +: NUM_IRQ]),
    .ack     (ack_take),
    .im      (status[ST_IM_LO +: NUM_IRQ]),
    .ip      (ip),
    .pend    (pend),
    .pend_id (pend_id)
  );

  // Cause keeps only IP and ExcCode. Every other bit reads 0.
  always_comb begin
    cause_val                       = '0;
    cause_val[CA_IP_LO +: NUM_IRQ]  = ip;
    cause_val[CA_EXC_HI:CA_EXC_LO]  = exc;
  end

  always_comb begin
    r_data = '0;
    if (r_sel == '0 && r_addr == REG_STATUS)     r_data = status;
    else if (r_sel == '0 && r_addr == REG_CAUSE) r_data = cause_val;
    else if (r_sel == '0 && r_addr == REG_EPC)   r_data = epc;
    else if (r_ok)                               r_data = mem[r_idx];
  end

  // The MTC0 value lands first. The hardware updates come after it in the
  // same block, so they override only the fields they own. An acknowledge
  // also masks an ERET on the same edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      status <= '0;
      epc    <= '0;
      exc    <= EXC_INT;
    end else begin
      if (w_status) status <= w_data;
      if (w_epc)    epc    <= w_data;
      if (w_cause)  exc    <= w_data[CA_EXC_HI:CA_EXC_LO];
      if (ack_take) begin
        status[ST_EXL] <= 1'b1;
        epc            <= epc_in;
        exc            <= EXC_INT;
      end else if (eret && status[ST_EXL]) begin
        status[ST_EXL] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (w_plain) begin
      mem[w_idx] <= w_data;
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  r_addr;
  logic [2:0]  r_sel;
  logic [31:0] r_data;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [2:0]  w_sel;
  logic [31:0] w_data;
  logic [7:0]  irq;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic        irq_ack;
  logic [31:0] epc_in;
  logic        eret;
  logic [31:0] epc_out;
  logic        status_exl;

  int total = 0;
  int bad   = 0;

  cp0_ctrl #(.WIDTH(32), .NUM_SEL(8), .NUM_IRQ(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .r_addr     (r_addr),
    .r_sel      (r_sel),
    .r_data     (r_data),
    .w_en       (w_en),
    .w_addr     (w_addr),
    .w_sel      (w_sel),
    .w_data     (w_data),
    .irq        (irq),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .epc_in     (epc_in),
    .eret       (eret),
    .epc_out    (epc_out),
    .status_exl (status_exl)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Architectural view: one storage word per (addr, sel), plus Status, the
  // Cause fields, EPC and the last observed irq levels.
  logic [31:0] m_mem [32][8];
  logic [31:0] m_status;
  logic [4:0]  m_exc;
  logic [31:0] m_epc;
  logic [7:0]  m_ip;
  logic [7:0]  m_prev;

  task automatic model_reset();
    for (int a = 0; a < 32; a++)
      for (int s = 0; s < 8; s++) m_mem[a][s] = '0;
    m_status = '0;
    m_exc    = '0;
    m_epc    = '0;
    m_ip     = '0;
    // Lines present at reset count as already high: only a fresh 0->1 sets IP.
    m_prev   = 8'hFF;
  endtask

  function automatic logic m_req();
    return m_status[0] && !m_status[1] && ((m_ip & m_status[15:8]) != 8'h00);
  endfunction

  function automatic logic [2:0] m_id();
    logic [7:0] p;
    p = m_ip & m_status[15:8];
    if (!m_req()) return 3'd0;
    for (int i = 0; i < 8; i++) if (p[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    if (s == 3'd0 && a == 5'd12) return m_status;
    if (s == 3'd0 && a == 5'd13) return {16'h0, m_ip, 1'b0, m_exc, 2'b00};
    if (s == 3'd0 && a == 5'd14) return m_epc;
    return m_mem[a][s];
  endfunction

  // One clock edge of architectural behaviour, computed from the inputs
  // present just before the edge.
  task automatic model_edge();
    logic       take;
    logic [2:0] id;
    logic [7:0] ip_n;
    logic       exl_old;
    take    = irq_ack && m_req();
    id      = m_id();
    exl_old = m_status[1];
    ip_n    = m_ip;
    if (w_en) begin
      if (w_sel == 0 && w_addr == 5'd12)      m_status = w_data;
      else if (w_sel == 0 && w_addr == 5'd13) begin ip_n = w_data[15:8]; m_exc = w_data[6:2]; end
      else if (w_sel == 0 && w_addr == 5'd14) m_epc = w_data;
      else                                    m_mem[w_addr][w_sel] = w_data;
    end
    if (take) begin
      m_epc       = epc_in;
      m_status[1] = 1'b1;
      m_exc       = 5'd0;
      ip_n[id]    = 1'b0;
    end else if (eret && exl_old) begin
      m_status[1] = 1'b0;
    end
    m_ip   = ip_n | (irq & ~m_prev);
    m_prev = irq;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".r_data"},  r_data,     m_read(r_addr, r_sel));
    chk({tag, ".irq_req"}, irq_req,    m_req());
    chk({tag, ".irq_id"},  irq_id,     m_id());
    chk({tag, ".epc"},     epc_out,    m_epc);
    chk({tag, ".exl"},     status_exl, m_status[1]);
  endtask

  // ---------------- drivers ----------------
  // Inputs are driven 1 time unit after a rising edge. Just before the next
  // edge the read port must still show the old value (no write-through).
  task automatic tick(input string tag);
    @(negedge clk);
    chk({tag, ".pre_rd"}, r_data, m_read(r_addr, r_sel));
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    w_en = 0; irq_ack = 0; eret = 0;
  endtask

  task automatic do_reset(input string tag);
    clr = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    clr = 1'b0;
    check_all(tag);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d,
                      input string tag);
    w_en = 1; w_addr = a; w_sel = s; w_data = d;
    tick(tag);
    w_en = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [2:0] s);
    r_addr = a; r_sel = s;
  endtask

  // ---------------- directed sequence then random ----------------
  initial begin
    clr = 0; r_addr = 0; r_sel = 0; w_en = 0; w_addr = 0; w_sel = 0; w_data = 0;
    irq = 0; irq_ack = 0; epc_in = 0; eret = 0;
    model_reset();
    #2;
    do_reset("reset");
    chk("reset_rdata", r_data, 32'h0);

    // Banked storage
    rd(5'd5, 3'd3);
    mtc0(5'd5, 3'd3, 32'hDEADBEEF, "w_5_3");
    chk("rd_5_3", r_data, 32'hDEADBEEF);
    mtc0(5'd5, 3'd0, 32'h1, "w_5_0");
    rd(5'd5, 3'd0);
    tick("idle_5_0");
    chk("rd_5_0", r_data, 32'h1);
    do_reset("clr_pulse");
    chk("clr_5_0", r_data, 32'h0);
    rd(5'd5, 3'd3);
    tick("idle_5_3");
    chk("clr_5_3", r_data, 32'h0);

    // Priority and acknowledge
    rd(5'd13, 3'd0);
    mtc0(5'd12, 3'd0, 32'h0000_0301, "w_status");
    irq = 8'h02; tick("irq1_hi");
    irq = 8'h00; tick("irq1_lo");
    irq = 8'h01; tick("irq0_hi");
    irq = 8'h00; tick("irq0_lo");
    chk("prio_req", irq_req, 1'b1);
    chk("prio_id",  irq_id,  3'd0);
    irq_ack = 1; epc_in = 32'h0040_0010; tick("ack0");
    irq_ack = 0;
    chk("ack0_epc", epc_out, 32'h0040_0010);
    chk("ack0_exl", status_exl, 1'b1);
    chk("ack0_ip",  r_data[15:8], 8'h02);
    chk("ack0_req", irq_req, 1'b0);

    eret = 1; tick("eret1"); eret = 0;
    chk("eret1_exl", status_exl, 1'b0);
    chk("eret1_req", irq_req, 1'b1);
    chk("eret1_id",  irq_id, 3'd1);
    irq_ack = 1; epc_in = 32'h0040_0020; tick("ack1"); irq_ack = 0;
    chk("ack1_ip", r_data[15:8], 8'h00);
    eret = 1; tick("eret2"); eret = 0;

    // ack and eret on the same edge: ack wins
    irq = 8'h01; tick("irq0_hi2");
    irq = 8'h00; tick("irq0_lo2");
    irq_ack = 1; eret = 1; epc_in = 32'h0000_0abc; tick("ack_eret");
    idle_inputs();
    chk("ack_eret_exl", status_exl, 1'b1);
    eret = 1; tick("eret3"); eret = 0;

    // New edge beats an MTC0 clear of Cause
    irq = 8'h04;
    mtc0(5'd13, 3'd0, 32'h0, "edge_vs_mtc0");
    irq = 8'h00;
    chk("edge_vs_mtc0_ip2", r_data[10], 1'b1);

    // A held line does not re-request after acknowledge
    mtc0(5'd13, 3'd0, 32'h0, "cause_clr");
    irq = 8'h01; tick("hold_rise");
    chk("hold_req", irq_req, 1'b1);
    irq_ack = 1; epc_in = 32'h0000_1000; tick("hold_ack"); irq_ack = 0;
    eret = 1; tick("hold_eret"); eret = 0;
    for (int i = 0; i < 4; i++) begin
      tick("hold");
      chk("hold_no_req", irq_req, 1'b0);
      chk("hold_ip0",    r_data[8], 1'b0);
    end
    irq = 8'h00; tick("hold_low");
    irq = 8'h01; tick("hold_rerise");
    chk("rerise_ip0", r_data[8], 1'b1);
    chk("rerise_req", irq_req, 1'b1);

    // Reset while the line stays high: no edge afterwards
    do_reset("clr_held");
    for (int i = 0; i < 3; i++) begin
      tick("post_clr_held");
      chk("post_clr_ip", r_data, 32'h0);
    end
    irq = 8'h00;

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] regs [5];
      regs[0] = 5'd5; regs[1] = 5'd12; regs[2] = 5'd13; regs[3] = 5'd14;
      regs[4] = 5'($urandom_range(0, 31));
      w_en    = ($urandom_range(0, 3) == 0);
      w_addr  = regs[$urandom_range(0, 4)];
      w_sel   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      w_data  = $urandom;
      if (w_addr == 5'd12 && $urandom_range(0, 1) == 0) w_data[1] = 1'b0;
      irq     = 8'($urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      eret    = ($urandom_range(0, 3) == 0);
      epc_in  = $urandom;
      r_addr  = regs[$urandom_range(0, 4)];
      r_sel   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      tick("rand");
    end
    idle_inputs();
    irq = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
